// File: rtl/exe_stage_mc_if.sv
// Handshaked operand/result bundle between the ID/EXE register, the
// execute stage and the EXE/MEM register.
interface exe_stage_mc_if #(
    parameter int WIDTH = 32,
    parameter int IMM_W = 24
);
    // Upstream operand bundle
    logic             in_valid;
    logic             in_ready;
    logic [3:0]       EXE_CMD;
    logic             MEM_R_EN;
    logic             MEM_W_EN;
    logic [WIDTH-1:0] PC;
    logic [WIDTH-1:0] Val_Rn;
    logic [WIDTH-1:0] Val2;
    logic [IMM_W-1:0] signed_imm;
    logic [3:0]       SR;

    // Downstream result slot
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] ALU_result;
    logic [WIDTH-1:0] Br_addr;
    logic [3:0]       status;
    logic             mem_r_en_o;
    logic             mem_w_en_o;

    // Pipeline side: supplies operands, consumes results
    modport master (
        output in_valid, EXE_CMD, MEM_R_EN, MEM_W_EN, PC, Val_Rn, Val2,
               signed_imm, SR, out_ready,
        input  in_ready, out_valid, ALU_result, Br_addr, status,
               mem_r_en_o, mem_w_en_o
    );

    // Execute stage side
    modport slave (
        input  in_valid, EXE_CMD, MEM_R_EN, MEM_W_EN, PC, Val_Rn, Val2,
               signed_imm, SR, out_ready,
        output in_ready, out_valid, ALU_result, Br_addr, status,
               mem_r_en_o, mem_w_en_o
    );
endinterface

// File: rtl/exe_stage_mc.sv
// Execute stage with a registered output slot: single-cycle ALU ops with
// N/Z/C/V status and branch-target computation, plus an iterative
// shift-add multiplier that occupies the stage for WIDTH cycles.
module exe_stage_mc #(
    parameter int WIDTH  = 32,
    parameter int IMM_W  = 24,
    parameter int MUL_EN = 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          flush,
    exe_stage_mc_if.slave bus
);
    localparam int CNT_W = $clog2(WIDTH + 1);

    localparam logic [3:0] CMD_MOV = 4'b0001;
    localparam logic [3:0] CMD_MVN = 4'b1001;
    localparam logic [3:0] CMD_ADD = 4'b0010;
    localparam logic [3:0] CMD_ADC = 4'b0011;
    localparam logic [3:0] CMD_SUB = 4'b0100;
    localparam logic [3:0] CMD_SBC = 4'b0101;
    localparam logic [3:0] CMD_AND = 4'b0110;
    localparam logic [3:0] CMD_ORR = 4'b0111;
    localparam logic [3:0] CMD_EOR = 4'b1000;
    localparam logic [3:0] CMD_MUL = 4'b1010;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_t;

    // Build {N,Z,C,V} from a result and the carry/overflow to report
    function automatic logic [3:0] nzcv(input logic [WIDTH-1:0] res,
                                        input logic c, input logic v);
        return {res[WIDTH-1], (res == {WIDTH{1'b0}}), c, v};
    endfunction

    // Control state
    state_t           state_r;
    state_t           state_nxt_s;
    logic [CNT_W-1:0] cnt_r;

    // Multiplier working registers and values held for its completion
    logic [WIDTH-1:0] acc_r;
    logic [WIDTH-1:0] mcand_r;
    logic [WIDTH-1:0] mplier_r;
    logic [1:0]       sr_cv_r;
    logic [WIDTH-1:0] br_hold_r;
    logic             mem_r_hold_r;
    logic             mem_w_hold_r;

    // Output slot
    logic             out_valid_r;
    logic [WIDTH-1:0] alu_result_r;
    logic [WIDTH-1:0] br_addr_r;
    logic [3:0]       status_r;
    logic             mem_r_en_r;
    logic             mem_w_en_r;

    // Combinational datapath
    logic             in_ready_s;
    logic             accept_s;
    logic             is_mul_s;
    logic             mul_last_s;
    logic             load_alu_s;
    logic             load_mul_s;
    logic [WIDTH-1:0] acc_step_s;
    logic [WIDTH-1:0] imm_ext_s;
    logic [WIDTH-1:0] br_s;
    logic             sub_s;
    logic             cin_s;
    logic [WIDTH-1:0] op_b_s;
    logic [WIDTH:0]   sum_ext_s;
    logic             add_v_s;
    logic [WIDTH-1:0] alu_res_s;
    logic [3:0]       alu_flags_s;

    // Handshake: accept only in IDLE with a free (or draining) slot and no flush
    always_comb begin
        in_ready_s = (state_r == ST_IDLE) && (!out_valid_r || bus.out_ready) && !flush;
        accept_s   = bus.in_valid && in_ready_s;
        is_mul_s   = (MUL_EN != 0) && (bus.EXE_CMD == CMD_MUL);
        mul_last_s = (state_r == ST_BUSY) && (cnt_r == CNT_W'(1));
        load_alu_s = accept_s && !is_mul_s;
        load_mul_s = mul_last_s && !flush;
        acc_step_s = mplier_r[0] ? (acc_r + mcand_r) : acc_r;
    end

    // Branch target: PC plus the word offset sign-extended and scaled to bytes
    always_comb begin
        imm_ext_s = {{(WIDTH - IMM_W){bus.signed_imm[IMM_W-1]}}, bus.signed_imm};
        br_s      = bus.PC + {imm_ext_s[WIDTH-3:0], 2'b00};
    end

    // Shared adder: subtraction is Rn + ~Val2 + carry-in, so C is NOT borrow
    always_comb begin
        sub_s  = (bus.EXE_CMD == CMD_SUB) || (bus.EXE_CMD == CMD_SBC);
        op_b_s = sub_s ? ~bus.Val2 : bus.Val2;
        case (bus.EXE_CMD)
            CMD_ADC: cin_s = bus.SR[1];
            CMD_SUB: cin_s = 1'b1;
            CMD_SBC: cin_s = bus.SR[1];
            default: cin_s = 1'b0;
        endcase
        sum_ext_s = {1'b0, bus.Val_Rn} + {1'b0, op_b_s} + {{WIDTH{1'b0}}, cin_s};
        add_v_s   = (bus.Val_Rn[WIDTH-1] == op_b_s[WIDTH-1]) &&
                    (sum_ext_s[WIDTH-1] != bus.Val_Rn[WIDTH-1]);
    end

    // Single-cycle result and flags; unknown codes (and MUL when disabled) act as NOP
    always_comb begin
        alu_res_s   = {WIDTH{1'b0}};
        alu_flags_s = bus.SR;
        case (bus.EXE_CMD)
            CMD_MOV: begin
                alu_res_s   = bus.Val2;
                alu_flags_s = nzcv(bus.Val2, bus.SR[1], bus.SR[0]);
            end
            CMD_MVN: begin
                alu_res_s   = ~bus.Val2;
                alu_flags_s = nzcv(~bus.Val2, bus.SR[1], bus.SR[0]);
            end
            CMD_ADD, CMD_ADC, CMD_SUB, CMD_SBC: begin
                alu_res_s   = sum_ext_s[WIDTH-1:0];
                alu_flags_s = nzcv(sum_ext_s[WIDTH-1:0], sum_ext_s[WIDTH], add_v_s);
            end
            CMD_AND: begin
                alu_res_s   = bus.Val_Rn & bus.Val2;
                alu_flags_s = nzcv(bus.Val_Rn & bus.Val2, bus.SR[1], bus.SR[0]);
            end
            CMD_ORR: begin
                alu_res_s   = bus.Val_Rn | bus.Val2;
                alu_flags_s = nzcv(bus.Val_Rn | bus.Val2, bus.SR[1], bus.SR[0]);
            end
            CMD_EOR: begin
                alu_res_s   = bus.Val_Rn ^ bus.Val2;
                alu_flags_s = nzcv(bus.Val_Rn ^ bus.Val2, bus.SR[1], bus.SR[0]);
            end
            default: begin
                alu_res_s   = {WIDTH{1'b0}};
                alu_flags_s = bus.SR;
            end
        endcase
    end

    // FSM state register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // FSM next state: MUL accept enters BUSY; flush or final step returns to IDLE
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (accept_s && is_mul_s) begin
                    state_nxt_s = ST_BUSY;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_BUSY: begin
                if (flush || mul_last_s) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_BUSY;
                end
            end
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // Multiplier: latch operands on accept, then one shift-add step per cycle
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_r        <= {CNT_W{1'b0}};
            acc_r        <= {WIDTH{1'b0}};
            mcand_r      <= {WIDTH{1'b0}};
            mplier_r     <= {WIDTH{1'b0}};
            sr_cv_r      <= 2'b00;
            br_hold_r    <= {WIDTH{1'b0}};
            mem_r_hold_r <= 1'b0;
            mem_w_hold_r <= 1'b0;
        end else if (flush) begin
            cnt_r <= {CNT_W{1'b0}};
        end else if (accept_s && is_mul_s) begin
            cnt_r        <= CNT_W'(WIDTH);
            acc_r        <= {WIDTH{1'b0}};
            mcand_r      <= bus.Val_Rn;
            mplier_r     <= bus.Val2;
            sr_cv_r      <= bus.SR[1:0];
            br_hold_r    <= br_s;
            mem_r_hold_r <= bus.MEM_R_EN;
            mem_w_hold_r <= bus.MEM_W_EN;
        end else if (state_r == ST_BUSY) begin
            acc_r    <= acc_step_s;
            mcand_r  <= {mcand_r[WIDTH-2:0], 1'b0};
            mplier_r <= {1'b0, mplier_r[WIDTH-1:1]};
            cnt_r    <= cnt_r - CNT_W'(1);
        end
    end

    // Output slot: load wins over consume, flush empties it without touching data
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_valid_r  <= 1'b0;
            alu_result_r <= {WIDTH{1'b0}};
            br_addr_r    <= {WIDTH{1'b0}};
            status_r     <= 4'b0000;
            mem_r_en_r   <= 1'b0;
            mem_w_en_r   <= 1'b0;
        end else if (flush) begin
            out_valid_r <= 1'b0;
        end else if (load_alu_s) begin
            out_valid_r  <= 1'b1;
            alu_result_r <= alu_res_s;
            br_addr_r    <= br_s;
            status_r     <= alu_flags_s;
            mem_r_en_r   <= bus.MEM_R_EN;
            mem_w_en_r   <= bus.MEM_W_EN;
        end else if (load_mul_s) begin
            out_valid_r  <= 1'b1;
            alu_result_r <= acc_step_s;
            br_addr_r    <= br_hold_r;
            status_r     <= nzcv(acc_step_s, sr_cv_r[1], sr_cv_r[0]);
            mem_r_en_r   <= mem_r_hold_r;
            mem_w_en_r   <= mem_w_hold_r;
        end else if (bus.out_ready) begin
            out_valid_r <= 1'b0;
        end
    end

    assign bus.in_ready   = in_ready_s;
    assign bus.out_valid  = out_valid_r;
    assign bus.ALU_result = alu_result_r;
    assign bus.Br_addr    = br_addr_r;
    assign bus.status     = status_r;
    assign bus.mem_r_en_o = mem_r_en_r;
    assign bus.mem_w_en_o = mem_w_en_r;

endmodule

// File: tb/tb_exe_stage_mc.sv
// Directed bench for exe_stage_mc: table of single-cycle vectors plus
// hand sequences for MUL latency, backpressure, flush and mid-run reset.
module tb_exe_stage_mc;
    logic clk;
    logic rst;
    logic flush;

    int n_vec;
    int n_err;

    exe_stage_mc_if #(.WIDTH(32), .IMM_W(24)) bus ();

    exe_stage_mc #(.WIDTH(32), .IMM_W(24), .MUL_EN(1)) dut (
        .clk   (clk),
        .rst   (rst),
        .flush (flush),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  cmd;
        logic [31:0] rn;
        logic [31:0] v2;
        logic [31:0] pc;
        logic [23:0] imm;
        logic [3:0]  sr;
        logic        mr;
        logic        mw;
        logic [31:0] res;
        logic [31:0] br;
        logic [3:0]  st;
    } vec_t;

    vec_t vecs [14];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: actual %0h required %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [3:0] cmd, input logic [31:0] rn, input logic [31:0] v2,
                         input logic [31:0] pc, input logic [23:0] imm, input logic [3:0] sr,
                         input logic mr, input logic mw);
        bus.in_valid   = 1'b1;
        bus.EXE_CMD    = cmd;
        bus.Val_Rn     = rn;
        bus.Val2       = v2;
        bus.PC         = pc;
        bus.signed_imm = imm;
        bus.SR         = sr;
        bus.MEM_R_EN   = mr;
        bus.MEM_W_EN   = mw;
    endtask

    // Watchdog so the run always ends
    initial begin
        #200000;
        $display("FAIL watchdog: actual timeout required finish");
        $fatal(1, "timeout");
    end

    initial begin
        int  n;
        logic bad;

        n_vec = 0;
        n_err = 0;
        //                cmd      rn            v2            pc            imm         sr       mr    mw    res           br            st
        vecs[0]  = '{4'b0010, 32'h7FFF_FFFF, 32'h0000_0001, 32'h0000_0100, 24'hFFFFFE, 4'b0000, 1'b0, 1'b0, 32'h8000_0000, 32'h0000_00F8, 4'b1001};
        vecs[1]  = '{4'b0100, 32'h0000_0005, 32'h0000_0005, 32'h0000_0000, 24'h000001, 4'b0000, 1'b0, 1'b0, 32'h0000_0000, 32'h0000_0004, 4'b0110};
        vecs[2]  = '{4'b0011, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_1000, 24'h000000, 4'b0010, 1'b0, 1'b0, 32'h0000_0000, 32'h0000_1000, 4'b0110};
        vecs[3]  = '{4'b0101, 32'h0000_000A, 32'h0000_0003, 32'h0000_0200, 24'h000010, 4'b0000, 1'b0, 1'b0, 32'h0000_0006, 32'h0000_0240, 4'b0010};
        vecs[4]  = '{4'b0100, 32'h0000_0003, 32'h0000_0005, 32'h8000_0000, 24'h7FFFFF, 4'b0000, 1'b0, 1'b0, 32'hFFFF_FFFE, 32'h81FF_FFFC, 4'b1000};
        vecs[5]  = '{4'b0001, 32'h1234_5678, 32'h0000_0000, 32'h0000_0010, 24'h800000, 4'b0011, 1'b1, 1'b0, 32'h0000_0000, 32'hFE00_0010, 4'b0111};
        vecs[6]  = '{4'b1001, 32'h0000_0000, 32'h0000_0000, 32'h0000_0004, 24'h000000, 4'b0001, 1'b0, 1'b1, 32'hFFFF_FFFF, 32'h0000_0004, 4'b1001};
        vecs[7]  = '{4'b0110, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 32'h0000_0008, 24'h000003, 4'b0010, 1'b0, 1'b0, 32'h00F0_00F0, 32'h0000_0014, 4'b0010};
        vecs[8]  = '{4'b0111, 32'h1234_0000, 32'h0000_5678, 32'h0000_0000, 24'h000000, 4'b0000, 1'b0, 1'b0, 32'h1234_5678, 32'h0000_0000, 4'b0000};
        vecs[9]  = '{4'b1000, 32'hAAAA_AAAA, 32'hAAAA_AAAA, 32'h0000_0020, 24'hFFFFFF, 4'b1100, 1'b0, 1'b0, 32'h0000_0000, 32'h0000_001C, 4'b0100};
        vecs[10] = '{4'b0000, 32'h0000_0005, 32'h0000_0006, 32'h0000_0030, 24'h000000, 4'b1011, 1'b0, 1'b0, 32'h0000_0000, 32'h0000_0030, 4'b1011};
        vecs[11] = '{4'b1111, 32'h0000_0005, 32'h0000_0006, 32'hFFFF_FFFC, 24'h000001, 4'b0101, 1'b1, 1'b1, 32'h0000_0000, 32'h0000_0000, 4'b0101};
        vecs[12] = '{4'b0010, 32'h8000_0000, 32'h8000_0000, 32'h0000_0000, 24'h000000, 4'b0000, 1'b0, 1'b0, 32'h0000_0000, 32'h0000_0000, 4'b0111};
        vecs[13] = '{4'b0011, 32'h0000_0001, 32'h0000_0002, 32'h0000_0000, 24'h000000, 4'b0010, 1'b0, 1'b0, 32'h0000_0004, 32'h0000_0000, 4'b0000};

        rst   = 1'b0;
        flush = 1'b0;
        drive(4'b0000, 32'h0, 32'h0, 32'h0, 24'h0, 4'b0000, 1'b0, 1'b0);
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
        chk("rst_result", bus.ALU_result, 32'd0);
        chk("rst_br", bus.Br_addr, 32'd0);
        chk("rst_status", {28'd0, bus.status}, 32'd0);
        chk("rst_mem", {30'd0, bus.mem_r_en_o, bus.mem_w_en_o}, 32'd0);
        rst = 1'b1;
        @(negedge clk);
        chk("rst_in_ready", {31'd0, bus.in_ready}, 32'd1);

        // Table-driven single-cycle vectors
        for (int i = 0; i < 14; i++) begin
            @(posedge clk); #1;
            drive(vecs[i].cmd, vecs[i].rn, vecs[i].v2, vecs[i].pc, vecs[i].imm,
                  vecs[i].sr, vecs[i].mr, vecs[i].mw);
            @(negedge clk);
            chk($sformatf("v%0d_in_ready", i), {31'd0, bus.in_ready}, 32'd1);
            @(posedge clk); #1;
            bus.in_valid = 1'b0;
            @(negedge clk);
            chk($sformatf("v%0d_out_valid", i), {31'd0, bus.out_valid}, 32'd1);
            chk($sformatf("v%0d_result", i), bus.ALU_result, vecs[i].res);
            chk($sformatf("v%0d_status", i), {28'd0, bus.status}, {28'd0, vecs[i].st});
            chk($sformatf("v%0d_br", i), bus.Br_addr, vecs[i].br);
            chk($sformatf("v%0d_mem", i), {30'd0, bus.mem_r_en_o, bus.mem_w_en_o},
                {30'd0, vecs[i].mr, vecs[i].mw});
        end

        // MUL: 0xFFFF x 0x10001, latency and in_ready low while busy
        @(posedge clk); #1;
        drive(4'b1010, 32'h0000_FFFF, 32'h0001_0001, 32'h0000_0400, 24'h000002, 4'b0101, 1'b1, 1'b0);
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        n   = 0;
        bad = 1'b0;
        while (n < 100) begin
            @(negedge clk);
            if (bus.out_valid) break;
            if (bus.in_ready) bad = 1'b1;
            @(posedge clk);
            n++;
        end
        chk("mul_latency", n, 32'd32);
        chk("mul_in_ready_low", {31'd0, bad}, 32'd0);
        chk("mul_result", bus.ALU_result, 32'hFFFF_FFFF);
        chk("mul_status", {28'd0, bus.status}, 32'h9);
        chk("mul_br", bus.Br_addr, 32'h0000_0408);
        chk("mul_mem", {30'd0, bus.mem_r_en_o, bus.mem_w_en_o}, 32'd2);

        // Backpressure: second ADD stalls, first result holds
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        drive(4'b0010, 32'd1, 32'd2, 32'h0, 24'h0, 4'b0000, 1'b0, 1'b0);
        @(posedge clk); #1;
        drive(4'b0010, 32'd10, 32'd20, 32'h0, 24'h0, 4'b0000, 1'b0, 1'b0);
        @(negedge clk);
        chk("bp_first", bus.ALU_result, 32'd3);
        chk("bp_in_ready_low", {31'd0, bus.in_ready}, 32'd0);
        @(posedge clk);
        @(negedge clk);
        chk("bp_hold_result", bus.ALU_result, 32'd3);
        chk("bp_hold_valid", {31'd0, bus.out_valid}, 32'd1);
        bus.out_ready = 1'b1;
        #1;
        chk("bp_in_ready_drain", {31'd0, bus.in_ready}, 32'd1);
        @(posedge clk); #1;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        @(negedge clk);
        chk("bp_swap_valid", {31'd0, bus.out_valid}, 32'd1);
        chk("bp_swap_result", bus.ALU_result, 32'd30);
        bus.out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("bp_consumed", {31'd0, bus.out_valid}, 32'd0);

        // Flush at cycle 10 of a MUL with in_valid also high
        @(posedge clk); #1;
        drive(4'b1010, 32'd3, 32'd4, 32'h0, 24'h0, 4'b0000, 1'b0, 1'b0);
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        flush = 1'b1;
        drive(4'b0010, 32'd7, 32'd8, 32'h0, 24'h0, 4'b0000, 1'b0, 1'b0);
        @(negedge clk);
        chk("fl_in_ready_low", {31'd0, bus.in_ready}, 32'd0);
        @(posedge clk); #1;
        flush        = 1'b0;
        bus.in_valid = 1'b0;
        @(negedge clk);
        chk("fl_out_valid", {31'd0, bus.out_valid}, 32'd0);
        chk("fl_in_ready", {31'd0, bus.in_ready}, 32'd1);
        bad = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (bus.out_valid) bad = 1'b1;
        end
        chk("fl_no_stale", {31'd0, bad}, 32'd0);
        chk("fl_data_kept", bus.ALU_result, 32'd30);

        // Reset asserted mid-MUL
        @(posedge clk); #1;
        drive(4'b1010, 32'd5, 32'd7, 32'h0, 24'h0, 4'b0000, 1'b0, 1'b0);
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        repeat (5) @(posedge clk);
        #3;
        rst = 1'b0;
        #1;
        chk("mrst_out_valid", {31'd0, bus.out_valid}, 32'd0);
        chk("mrst_result", bus.ALU_result, 32'd0);
        chk("mrst_status", {28'd0, bus.status}, 32'd0);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("mrst_in_ready", {31'd0, bus.in_ready}, 32'd1);
        bad = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (bus.out_valid) bad = 1'b1;
        end
        chk("mrst_aborted", {31'd0, bad}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
